// File: rtl/obstacle_scheduler_pkg.sv
// obstacle_scheduler_pkg: shared slot geometry, screen constants and mode/state encodings
package obstacle_scheduler_pkg;
  localparam int NUM_OBS = 10;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int X_STRIDE = 20;
  localparam int Y_STRIDE = 18;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int UPPER_BOUND = 20;
  localparam int LOWER_BOUND = 460;
  localparam int SPAWN_Y_BASE = 24;
  localparam int SPAWN_H_MIN = 40;
  localparam int SPAWN_H_STEP = 20;
  typedef enum logic [1:0] {GM_INIT = 2'b00, GM_RUN = 2'b01, GM_PAUSE = 2'b10, GM_OVER = 2'b11} gamemode_e;
  typedef enum logic [1:0] {IDLE, SCROLL, SPAWN, DONE} state_e;
  typedef struct packed {
    logic [XW-1:0] xl;
    logic [XW-1:0] xr;
    logic [YW-1:0] yt;
    logic [YW-1:0] yb;
  } slot_t;
endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, steps when en is high
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else if (en) q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end
endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: per-frame scroll of obstacle slots plus periodic LFSR-driven spawn
module obstacle_scheduler #(
  parameter int          NUM_OBS        = obstacle_scheduler_pkg::NUM_OBS,
  parameter int          SCROLL_STEP    = 2,
  parameter int          SPAWN_INTERVAL = 90,
  parameter int          OBS_W          = 40,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                frame_tick,
  input  logic [1:0]                                          gamemode,
  output logic [NUM_OBS*obstacle_scheduler_pkg::X_STRIDE-1:0] obstacle_x,
  output logic [NUM_OBS*obstacle_scheduler_pkg::Y_STRIDE-1:0] obstacle_y,
  output logic                                                busy
);
  import obstacle_scheduler_pkg::*;
  localparam logic [6:0] CNT_TOP = 7'(SPAWN_INTERVAL - 1);
  localparam logic [XW-1:0] STEP = XW'(SCROLL_STEP);
  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d, free_idx;
  logic [6:0] cnt_q, cnt_d;
  slot_t slot_q [NUM_OBS];
  slot_t slot_d [NUM_OBS];
  slot_t cur, scr, spn;
  logic [15:0] lfsr;
  logic [4:0] lfsr_unused;
  logic accept, free_found;
  assign accept = state_q == IDLE && frame_tick && gamemode == GM_RUN;
  assign busy = state_q != IDLE;
  assign lfsr_unused = lfsr[15:11];
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .en(accept), .q(lfsr));
  // x_right==0 marks a free slot, since active slots always keep x_left<x_right
  always_comb begin
    free_idx = '0;
    free_found = 1'b0;
    for (int i = NUM_OBS - 1; i >= 0; i--)
      if (slot_q[i].xr == '0) begin
        free_idx = 4'(i);
        free_found = 1'b1;
      end
    cur = slot_q[idx_q];
    scr = '0;
    if (cur.xr > STEP) begin
      scr = cur;
      scr.xr = cur.xr - STEP;
      scr.xl = cur.xl >= STEP ? cur.xl - STEP : '0;
    end
    spn.xl = XW'(SCREEN_W - OBS_W);
    spn.xr = XW'(SCREEN_W);
    spn.yt = YW'(SPAWN_Y_BASE) + YW'(lfsr[7:0]);
    spn.yb = spn.yt + YW'(SPAWN_H_MIN) + YW'(SPAWN_H_STEP * lfsr[10:8]);
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    slot_d = slot_q;
    if (gamemode == GM_INIT) begin
      state_d = IDLE;
      idx_d = '0;
      cnt_d = '0;
      for (int i = 0; i < NUM_OBS; i++) slot_d[i] = '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_d = SCROLL;
          idx_d = '0;
          cnt_d = cnt_q == CNT_TOP ? cnt_q : cnt_q + 7'd1;
        end
        SCROLL: begin
          slot_d[idx_q] = scr;
          idx_d = idx_q + 4'd1;
          state_d = idx_q == 4'(NUM_OBS - 1) ? SPAWN : SCROLL;
        end
        SPAWN: begin
          if (cnt_q == CNT_TOP && free_found) begin
            slot_d[free_idx] = spn;
            cnt_d = '0;
          end
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < NUM_OBS; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
    end
  end
  always_comb begin
    obstacle_x = '0;
    obstacle_y = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      obstacle_x[i*X_STRIDE +: XW] = slot_q[i].xl;
      obstacle_x[i*X_STRIDE+XW +: XW] = slot_q[i].xr;
      obstacle_y[i*Y_STRIDE +: YW] = slot_q[i].yt;
      obstacle_y[i*Y_STRIDE+YW +: YW] = slot_q[i].yb;
    end
  end
endmodule
